adder_byte_sequencer: RTL



---
 rtl/adder_byte_sequencer_if.sv | 29 ++
 rtl/adder_byte_sequencer.sv | 120 ++++++++++++
 2 files changed

// File: rtl/adder_byte_sequencer_if.sv
// Handshake bundle for adder_byte_sequencer: operand request side and result side.
// The overflow signal exists only when ADD_SEQ_OVERFLOW_EN is defined.
interface adder_byte_sequencer_if #(parameter int NBYTES = 4);
   localparam int W = 8 * NBYTES;

   logic         start_valid;
   logic         start_ready;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic         cin;
   logic         res_valid;
   logic         res_ready;
   logic [W-1:0] result;
   logic         cout;
   logic         busy;
`ifdef ADD_SEQ_OVERFLOW_EN
   logic         overflow;

   modport master (output start_valid, op_a, op_b, cin, res_ready,
                   input  start_ready, res_valid, result, cout, busy, overflow);
   modport slave  (input  start_valid, op_a, op_b, cin, res_ready,
                   output start_ready, res_valid, result, cout, busy, overflow);
`else
   modport master (output start_valid, op_a, op_b, cin, res_ready,
                   input  start_ready, res_valid, result, cout, busy);
   modport slave  (input  start_valid, op_a, op_b, cin, res_ready,
                   output start_ready, res_valid, result, cout, busy);
`endif
endinterface

// File: rtl/adder_byte_sequencer.sv
// Multi-precision adder: one shared 8-bit adder, one byte per clock, LSB first.
// Optional signed-overflow output enabled by defining ADD_SEQ_OVERFLOW_EN.
module simple_8bit_adder (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] sum,
   output logic       cout
);
   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};
endmodule

module adder_byte_sequencer #(
   parameter int NBYTES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   adder_byte_sequencer_if.slave  bus
);
   localparam int W  = 8 * NBYTES;
   localparam int IW = $clog2(NBYTES);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   idx_q, idx_d;
   logic            carry_q, carry_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [W-1:0]    result_q, result_d;
   logic            cout_q, cout_d;
   logic            ovf_q, ovf_d;

   logic [7:0]      add_a, add_b, add_sum;
   logic            add_co;

   assign add_a = a_q[8*idx_q +: 8];
   assign add_b = b_q[8*idx_q +: 8];

   simple_8bit_adder u_add (
      .a    (add_a),
      .b    (add_b),
      .cin  (carry_q),
      .sum  (add_sum),
      .cout (add_co)
   );

   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      unique case (state_q)
         IDLE: begin
            if (bus.start_valid) begin
               a_d      = bus.op_a;
               b_d      = bus.op_b;
               carry_d  = bus.cin;
               idx_d    = '0;
               result_d = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            result_d[8*idx_q +: 8] = add_sum;
            carry_d = add_co;
            idx_d   = idx_q + IW'(1);
            // Top byte: final carry and signed overflow are latched together.
            if (idx_q == IW'(NBYTES - 1)) begin
               cout_d  = add_co;
               ovf_d   = (a_q[W-1] == b_q[W-1]) && (add_sum[7] != a_q[W-1]);
               idx_d   = '0;
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         carry_q  <= carry_d;
         a_q      <= a_d;
         b_q      <= b_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovf_q    <= ovf_d;
      end
   end

   assign bus.start_ready = (state_q == IDLE);
   assign bus.res_valid   = (state_q == DONE);
   assign bus.busy        = (state_q != IDLE);
   assign bus.result      = result_q;
   assign bus.cout        = cout_q;
`ifdef ADD_SEQ_OVERFLOW_EN
   assign bus.overflow    = ovf_q;
`else
   logic unused_ovf;
   assign unused_ovf = ovf_q;
`endif
endmodule
